// File: rtl/lock_verifier.sv
// Keypad passcode verifier: digit entry, constant-time compare,
// failed-attempt counting with timed lockout, and code re-programming.
//
// Ports:
//   clk          system clock, all state on rising edge
//   resetn       asynchronous active-low reset
//   key_valid    strobe: key_digit holds a new digit
//   key_digit    entered digit value
//   submit       strobe: end of entry
//   relock       strobe: relock / clear entry
//   busy         high while comparing or locked out
//   unlocked     level: correct code accepted
//   fail_pulse   one-cycle pulse per rejected attempt
//   prog_done    one-cycle pulse: new passcode stored
//   lockout      level: lockout timer running
//   attempts     consecutive failed attempts
//   entry_count  digits currently buffered
module lock_verifier #(
    parameter int DIGIT_W        = 4,
    parameter int MAX_LEN        = 10,
    parameter int LEN_W          = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int DEFAULT_LEN    = 4,
    parameter     DEFAULT_CODE   = 16'h1234
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               submit,
    input  logic               relock,
    output logic               busy,
    output logic               unlocked,
    output logic               fail_pulse,
    output logic               prog_done,
    output logic               lockout,
    output logic [2:0]         attempts,
    output logic [LEN_W-1:0]   entry_count
);

    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TW-1:0]    T_LOAD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]       ATT_MAX = 3'(MAX_ATTEMPTS);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_DEF = LEN_W'(DEFAULT_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    // Digit k of the reset passcode; digit 0 sits in the top bits.
    function automatic logic [DIGIT_W-1:0] default_digit(input int k);
        if (k < DEFAULT_LEN)
            return DIGIT_W'(DEFAULT_CODE >> ((DEFAULT_LEN - 1 - k) * DIGIT_W));
        return '0;
    endfunction

    state_t             state;
    logic [DIGIT_W-1:0] entry_buf [MAX_LEN];
    logic [DIGIT_W-1:0] code_buf  [MAX_LEN];
    logic [LEN_W-1:0]   code_len;
    logic [LEN_W-1:0]   idx;
    logic               ovf;
    logic               mism;
    logic [TW-1:0]      timer;

    logic               clr_entry;
    logic               take_key;
    logic               check_done;
    logic [2:0]         att_next;

    assign check_done = (idx == code_len);
    assign att_next   = (attempts == ATT_MAX) ? ATT_MAX : attempts + 3'd1;

    // Who owns the entry buffer this cycle.
    always_comb begin
        clr_entry = 1'b0;
        take_key  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!submit) begin
                    if (relock)
                        clr_entry = 1'b1;
                    else if (key_valid)
                        take_key = 1'b1;
                end
            end
            S_CHECK: begin
                clr_entry = check_done;
            end
            S_UNLOCKED: begin
                if (relock || submit)
                    clr_entry = 1'b1;
                else if (key_valid)
                    take_key = 1'b1;
            end
            S_LOCKOUT: begin
                clr_entry = 1'b0;
            end
        endcase
    end

    // Entry buffer; a full buffer drops the digit and flags overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entry_count <= '0;
            ovf         <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++)
                entry_buf[k] <= '0;
        end else if (clr_entry) begin
            entry_count <= '0;
            ovf         <= 1'b0;
            for (int k = 0; k < MAX_LEN; k++)
                entry_buf[k] <= '0;
        end else if (take_key) begin
            if (entry_count == LEN_MAX) begin
                ovf <= 1'b1;
            end else begin
                entry_buf[entry_count] <= key_digit;
                entry_count            <= entry_count + 1'b1;
            end
        end
    end

    // Control FSM. The compare always walks all code_len digits so the
    // time to reject does not leak how many leading digits were right.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            code_len   <= LEN_DEF;
            idx        <= '0;
            mism       <= 1'b0;
            timer      <= '0;
            busy       <= 1'b0;
            unlocked   <= 1'b0;
            fail_pulse <= 1'b0;
            prog_done  <= 1'b0;
            lockout    <= 1'b0;
            attempts   <= '0;
            for (int k = 0; k < MAX_LEN; k++)
                code_buf[k] <= default_digit(k);
        end else begin
            fail_pulse <= 1'b0;
            prog_done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (submit) begin
                        state <= S_CHECK;
                        busy  <= 1'b1;
                        idx   <= '0;
                        mism  <= (entry_count != code_len) || ovf;
                    end
                end
                S_CHECK: begin
                    if (!check_done) begin
                        if (entry_buf[idx] != code_buf[idx])
                            mism <= 1'b1;
                        idx <= idx + 1'b1;
                    end else if (!mism) begin
                        state    <= S_UNLOCKED;
                        busy     <= 1'b0;
                        unlocked <= 1'b1;
                        attempts <= '0;
                    end else begin
                        fail_pulse <= 1'b1;
                        attempts   <= att_next;
                        if (att_next == ATT_MAX) begin
                            state   <= S_LOCKOUT;
                            lockout <= 1'b1;
                            timer   <= T_LOAD;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (relock) begin
                        state    <= S_IDLE;
                        unlocked <= 1'b0;
                    end else if (submit && entry_count != '0 && !ovf) begin
                        code_len  <= entry_count;
                        prog_done <= 1'b1;
                        for (int k = 0; k < MAX_LEN; k++)
                            code_buf[k] <= entry_buf[k];
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        lockout  <= 1'b0;
                        attempts <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_verifier.sv
// Self-checking bench for lock_verifier: directed scenarios plus
// randomized episodes, checked every cycle against a queue-based model.
module tb_lock_verifier;

    localparam int DW = 4;
    localparam int ML = 10;
    localparam int LW = 4;
    localparam int MA = 3;
    localparam int LC = 1000;
    localparam int DL = 4;

    localparam int M_IDLE  = 0;
    localparam int M_CHECK = 1;
    localparam int M_UNL   = 2;
    localparam int M_LOCK  = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          key_valid = 1'b0;
    logic [DW-1:0] key_digit = '0;
    logic          submit = 1'b0;
    logic          relock = 1'b0;
    logic          busy;
    logic          unlocked;
    logic          fail_pulse;
    logic          prog_done;
    logic          lockout;
    logic [2:0]    attempts;
    logic [LW-1:0] entry_count;

    always #5 clk = ~clk;

    lock_verifier #(
        .DIGIT_W(DW), .MAX_LEN(ML), .LEN_W(LW),
        .MAX_ATTEMPTS(MA), .LOCKOUT_CYCLES(LC),
        .DEFAULT_LEN(DL), .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk), .resetn(resetn),
        .key_valid(key_valid), .key_digit(key_digit),
        .submit(submit), .relock(relock),
        .busy(busy), .unlocked(unlocked),
        .fail_pulse(fail_pulse), .prog_done(prog_done),
        .lockout(lockout), .attempts(attempts),
        .entry_count(entry_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model
    int mode;
    int ent[$];
    int code[$];
    bit m_ovf;
    bit chk_ok;
    int chk_left;
    int lock_left;
    int m_att;
    bit e_fail;
    bit e_prog;

    int n_busy, n_fail, n_prog, n_lock;

    task automatic model_reset();
        mode = M_IDLE;
        ent.delete();
        code = {1, 2, 3, 4};
        m_ovf = 0;
        chk_ok = 0;
        chk_left = 0;
        lock_left = 0;
        m_att = 0;
        e_fail = 0;
        e_prog = 0;
    endtask

    task automatic clear_ent();
        ent.delete();
        m_ovf = 0;
    endtask

    task automatic add_key(int d);
        if (ent.size() < ML) ent.push_back(d);
        else m_ovf = 1;
    endtask

    function automatic bit code_matches();
        if (m_ovf) return 0;
        if (ent.size() != code.size()) return 0;
        foreach (code[i])
            if (ent[i] != code[i]) return 0;
        return 1;
    endfunction

    task automatic model_step(bit kv, int kd, bit sub, bit rl);
        e_fail = 0;
        e_prog = 0;
        case (mode)
            M_IDLE: begin
                if (sub) begin
                    chk_ok = code_matches();
                    chk_left = code.size();
                    mode = M_CHECK;
                end else if (rl) clear_ent();
                else if (kv) add_key(kd);
            end
            M_CHECK: begin
                if (chk_left > 0) begin
                    chk_left--;
                end else begin
                    clear_ent();
                    if (chk_ok) begin
                        mode = M_UNL;
                        m_att = 0;
                    end else begin
                        e_fail = 1;
                        m_att = (m_att + 1 > MA) ? MA : m_att + 1;
                        if (m_att == MA) begin
                            mode = M_LOCK;
                            lock_left = LC - 1;
                        end else mode = M_IDLE;
                    end
                end
            end
            M_UNL: begin
                if (rl) begin
                    clear_ent();
                    mode = M_IDLE;
                end else if (sub) begin
                    if (ent.size() > 0 && !m_ovf) begin
                        code = ent;
                        e_prog = 1;
                    end
                    clear_ent();
                end else if (kv) add_key(kd);
            end
            default: begin
                if (lock_left == 0) begin
                    mode = M_IDLE;
                    m_att = 0;
                end else lock_left--;
            end
        endcase
    endtask

    task automatic cmp(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("busy", busy, (mode == M_CHECK || mode == M_LOCK));
        cmp("unlocked", unlocked, mode == M_UNL);
        cmp("fail_pulse", fail_pulse, e_fail);
        cmp("prog_done", prog_done, e_prog);
        cmp("lockout", lockout, mode == M_LOCK);
        cmp("attempts", attempts, m_att);
        cmp("entry_count", entry_count, ent.size());
    endtask

    task automatic cyc(bit kv, int kd, bit sub, bit rl);
        @(negedge clk);
        key_valid = kv;
        key_digit = DW'(kd);
        submit = sub;
        relock = rl;
        @(posedge clk);
        model_step(kv, kd, sub, rl);
        #1;
        check_all();
        n_busy += busy;
        n_fail += fail_pulse;
        n_prog += prog_done;
        n_lock += lockout;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0);
    endtask

    task automatic type_seq(input int d[$]);
        foreach (d[i]) cyc(1, d[i], 0, 0);
    endtask

    // Submit, then report the first cycle (edges after submit) with a result.
    task automatic submit_wait(output int at);
        at = -1;
        cyc(0, 0, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            idle();
            if (at < 0 && (unlocked || fail_pulse)) at = i;
        end
    endtask

    task automatic pin_zero(string tag);
        cmp({tag, "_busy"}, busy, 0);
        cmp({tag, "_unlocked"}, unlocked, 0);
        cmp({tag, "_fail"}, fail_pulse, 0);
        cmp({tag, "_prog"}, prog_done, 0);
        cmp({tag, "_lockout"}, lockout, 0);
        cmp({tag, "_attempts"}, attempts, 0);
        cmp({tag, "_count"}, entry_count, 0);
    endtask

    initial begin
        #1_000_000_0;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_ok[$];
        int s_bad[$];
        int s[$];
        int at;
        int guard;

        model_reset();
        #12;
        pin_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        // 1: default code unlocks after 4 compares + result cycle
        s_ok = {1, 2, 3, 4};
        n_busy = 0;
        n_fail = 0;
        type_seq(s_ok);
        submit_wait(at);
        cmp("t1_unlock_at", at, 5);
        cmp("t1_busy_cycles", n_busy, 5);
        cmp("t1_fail_count", n_fail, 0);
        cmp("t1_attempts", attempts, 0);
        cyc(0, 0, 0, 1);

        // 2: wrong digit, then wrong length
        s_bad = {1, 2, 3, 5};
        type_seq(s_bad);
        n_fail = 0;
        submit_wait(at);
        cmp("t2_fail_at", at, 5);
        cmp("t2_fail_count", n_fail, 1);
        cmp("t2_attempts", attempts, 1);
        cmp("t2_count", entry_count, 0);
        s = {1, 2, 3};
        type_seq(s);
        submit_wait(at);
        cmp("t2_short_fail_at", at, 5);
        cmp("t2_attempts2", attempts, 2);

        // 3: third failure locks out; correct code during lockout ignored
        n_lock = 0;
        type_seq(s_bad);
        submit_wait(at);
        cmp("t3_fail_at", at, 5);
        type_seq(s_ok);
        cyc(0, 0, 1, 0);
        guard = 0;
        while (lockout && guard < 1100) begin
            idle();
            guard++;
        end
        cmp("t3_lock_cycles", n_lock, 1000);
        cmp("t3_unlocked", unlocked, 0);
        cmp("t3_attempts", attempts, 0);
        type_seq(s_ok);
        submit_wait(at);
        cmp("t3_unlock_at", at, 5);
        cyc(0, 0, 0, 1);

        // 4: overflow entry, and digit coincident with submit
        s = {1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
        type_seq(s);
        cmp("t4_count_cap", entry_count, 10);
        submit_wait(at);
        cmp("t4_fail_at", at, 5);
        s = {1, 2, 3};
        type_seq(s);
        cyc(1, 4, 1, 0);
        cmp("t4_coincident_count", entry_count, 3);
        for (int i = 0; i < 10; i++) idle();
        cmp("t4_attempts", attempts, 2);

        // 5: reprogram to a 6-digit code
        type_seq(s_ok);
        submit_wait(at);
        cmp("t5_unlock_at", at, 5);
        s = {9, 8, 7, 6, 5, 4};
        type_seq(s);
        cyc(0, 0, 1, 0);
        cmp("t5_prog_done", prog_done, 1);
        cyc(0, 0, 0, 1);
        type_seq(s_ok);
        submit_wait(at);
        cmp("t5_old_fail_at", at, 7);
        type_seq(s);
        n_busy = 0;
        submit_wait(at);
        cmp("t5_new_unlock_at", at, 7);
        cmp("t5_busy_cycles", n_busy, 7);
        cyc(0, 0, 0, 1);

        // 6: reset during CHECK reverts to default code
        type_seq(s_ok);
        cyc(0, 0, 1, 0);
        idle();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        pin_zero("t6_mid_reset");
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        type_seq(s_ok);
        submit_wait(at);
        cmp("t6_unlock_at", at, 5);
        cyc(0, 0, 0, 1);

        // Randomized episodes
        for (int ep = 0; ep < 120; ep++) begin
            int r;
            int len;
            r = $urandom_range(0, 99);
            s.delete();
            if (mode == M_UNL && r < 30) begin
                len = $urandom_range(0, 11);
                for (int i = 0; i < len; i++)
                    s.push_back($urandom_range(0, 15));
            end else if (r < 65) begin
                s = code;
            end else begin
                len = $urandom_range(0, 12);
                for (int i = 0; i < len; i++)
                    s.push_back($urandom_range(0, 15));
            end
            type_seq(s);
            if ($urandom_range(0, 9) < 2)
                cyc(0, 0, 0, 1);
            cyc($urandom_range(0, 1), $urandom_range(0, 15), 1, 0);
            len = $urandom_range(2, 16);
            for (int i = 0; i < len; i++)
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15),
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 15) == 0);
            if (mode == M_UNL && $urandom_range(0, 2) == 0)
                cyc(0, 0, $urandom_range(0, 1), 1);
            guard = 0;
            while ((mode == M_LOCK || mode == M_CHECK) && guard < 1100) begin
                idle();
                guard++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
